mesh_terminal_rx: RTL and testbench

- Synthesizable receive endpoint for one terminal of the mesh_gnrtr router array.
- Drains the router's per-terminal output port through the pndng/data_out/pop handshake and checks each packet's target address against its own row/column.
- Buffers accepted packets in a local FIFO for a local consumer, and keeps saturating receive and misroute counters.
- One instance per mesh terminal; it replaces the bench monitor as the hardware consumer of that port.

---
 rtl/mesh_terminal_rx.sv | 123 ++++++++++++
 tb/tb_mesh_terminal_rx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_terminal_rx.sv
// mesh_terminal_rx: receive endpoint for one mesh_gnrtr terminal port.
// Pops packets from the router, keeps the ones addressed to this terminal (or broadcast) in a
// circular buffer with a first-word-fall-through read port, and drops misrouted ones.
// Optional build macro TERM_RX_TIMESTAMP_EN adds a 32-bit cycle counter, per-entry POP
// timestamps and the ts_o output.
module mesh_terminal_rx #(
    parameter int unsigned PAKG_SIZE = 32,
    parameter int unsigned BUF_DEPTH = 8,
    parameter logic [3:0]  ROW_ID    = 4'd0,
    parameter logic [3:0]  COL_ID    = 4'd0,
    parameter logic [7:0]  BDCST     = 8'hFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pndng_i,
    input  logic [PAKG_SIZE-1:0] data_i,
    output logic                 pop_o,
    input  logic                 rd_en_i,
    output logic [PAKG_SIZE-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic [CNT_W-1:0]     rx_count_o,
    output logic [CNT_W-1:0]     misroute_count_o,
    output logic                 full_o
`ifdef TERM_RX_TIMESTAMP_EN
    ,
    output logic [31:0]          ts_o
`endif
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {StIdle, StPop, StSettle} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic [PAKG_SIZE-1:0] mem_q [BUF_DEPTH];
    logic [CNT_W-1:0]     rx_q, mis_q;

    logic [7:0] head_tgt;
    logic       hit, rd_fire, wr_fire, drop;

    assign head_tgt = data_i[PAKG_SIZE-9 -: 8];
    assign hit      = (head_tgt == {ROW_ID, COL_ID}) || (head_tgt == BDCST);

    assign rd_valid_o = (count_q != '0);
    assign full_o     = (count_q == DEPTH_C);
    assign rd_fire    = rd_en_i && rd_valid_o;
    // A concurrent read frees a slot, so a full buffer can still take the POP entry.
    assign wr_fire    = (state_q == StPop) && hit && (!full_o || rd_fire);
    assign drop       = (state_q == StPop) && !hit;

    assign rd_data_o        = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign rx_count_o       = rx_q;
    assign misroute_count_o = mis_q;

    // Next-state and pop strobe for the IDLE/POP/SETTLE handshake.
    always_comb begin
        state_d = state_q;
        pop_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Mismatching heads are drained even when full so they cannot block the port.
                if (pndng_i && (!full_o || !hit)) state_d = StPop;
            end
            StPop: begin
                pop_o   = 1'b1;
                state_d = StSettle;
            end
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, buffer pointers/occupancy and saturating status counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rx_q     <= '0;
            mis_q    <= '0;
        end else begin
            state_q <= state_d;
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_fire && !rd_fire) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (rd_fire && !wr_fire) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (wr_fire && (rx_q != '1)) rx_q <= rx_q + CNT_W'(1);
            if (drop && (mis_q != '1)) mis_q <= mis_q + CNT_W'(1);
        end
    end

    // Buffer storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= data_i;
    end

`ifdef TERM_RX_TIMESTAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] ts_mem_q [BUF_DEPTH];

    assign ts_o = rd_valid_o ? ts_mem_q[rd_ptr_q] : '0;

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_i) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end

    // Timestamp of the POP cycle stored alongside each accepted entry.
    always_ff @(posedge clk_i) begin
        if (wr_fire) ts_mem_q[wr_ptr_q] <= cyc_q;
    end
`endif

endmodule

// File: tb/tb_mesh_terminal_rx.sv
// Testbench for mesh_terminal_rx (ROW_ID=1, COL_ID=2, BUF_DEPTH=8); also exercises
// ts_o when built with TERM_RX_TIMESTAMP_EN.
module tb_mesh_terminal_rx;

    logic        clk = 1'b0;
    logic        rst_n, pndng, rd_en, pop, rd_valid, full;
    logic [31:0] data, rd_data;
    logic [15:0] rx_cnt, mis_cnt;
`ifdef TERM_RX_TIMESTAMP_EN
    logic [31:0] ts;
`endif

    always #5 clk = ~clk;

    mesh_terminal_rx #(
        .PAKG_SIZE(32), .BUF_DEPTH(8), .ROW_ID(4'd1), .COL_ID(4'd2), .BDCST(8'hFF), .CNT_W(16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .pndng_i          (pndng),
        .data_i           (data),
        .pop_o            (pop),
        .rd_en_i          (rd_en),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .rx_count_o       (rx_cnt),
        .misroute_count_o (mis_cnt),
        .full_o           (full)
`ifdef TERM_RX_TIMESTAMP_EN
        ,
        .ts_o             (ts)
`endif
    );

    // Reference model: router port contents, local buffer contents, counters.
    logic [31:0] router_q[$];
    logic [31:0] fifo_q[$];
    int unsigned ts_q[$];
    int unsigned rx_m, mis_m, tcyc;
    int          checks = 0, fails = 0, pops = 0, wait_cnt = 0;
    bit          prev_pop, pop_seen, rst_on_pop, did_rst;

    function automatic bit is_hit(logic [31:0] p);
        logic [7:0] t;
        t = p[23:16];
        return (t == 8'h12) || (t == 8'hFF);
    endfunction

    function automatic logic [31:0] mk_pkt(logic [7:0] tgt);
        logic [31:0] p;
        p = $urandom;
        p[23:16] = tgt;
        return p;
    endfunction

    task automatic clear_model();
        fifo_q.delete();
        ts_q.delete();
        rx_m = 0;
        mis_m = 0;
        tcyc = 0;
        prev_pop = 0;
        wait_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pndng = 1'b0;
        rd_en = 1'b0;
        data  = 32'h0;
        @(posedge clk);
        #1;
        router_q.delete();
        clear_model();
        rst_n = 1'b1;
    endtask

    // One clock cycle: compare at negedge, drive inputs, advance the model after posedge.
    task automatic step(input bit rd);
        logic [31:0] d_s;
        bit          p_s, r_s;
        int unsigned cyc_s;
        @(negedge clk);
        checks++;
        if (rd_valid !== (fifo_q.size() != 0)) begin
            fails++;
            $display("FAIL rd_valid: got %b want %b", rd_valid, fifo_q.size() != 0);
        end
        checks++;
        if (full !== (fifo_q.size() == 8)) begin
            fails++;
            $display("FAIL full: got %b want %b", full, fifo_q.size() == 8);
        end
        checks++;
        if (rx_cnt !== 16'(rx_m)) begin
            fails++;
            $display("FAIL rx_count: got %0d want %0d", rx_cnt, rx_m);
        end
        checks++;
        if (mis_cnt !== 16'(mis_m)) begin
            fails++;
            $display("FAIL misroute_count: got %0d want %0d", mis_cnt, mis_m);
        end
        if (fifo_q.size() != 0) begin
            checks++;
            if (rd_data !== fifo_q[0]) begin
                fails++;
                $display("FAIL rd_data: got %h want %h", rd_data, fifo_q[0]);
            end
        end
`ifdef TERM_RX_TIMESTAMP_EN
        checks++;
        if (ts !== ((fifo_q.size() != 0) ? ts_q[0] : 32'd0)) begin
            fails++;
            $display("FAIL ts: got %0d want %0d", ts, (fifo_q.size() != 0) ? ts_q[0] : 0);
        end
`endif
        pndng = (router_q.size() != 0);
        data  = pndng ? router_q[0] : 32'h0;
        rd_en = rd;
        p_s = pop;
        pop_seen = pop;
        d_s = data;
        r_s = rd;
        cyc_s = tcyc;
        if (p_s) begin
            pops++;
            checks++;
            if (prev_pop) begin
                fails++;
                $display("FAIL pop_spacing: got consecutive pops want gap");
            end
        end
        if (!p_s && router_q.size() != 0 && (fifo_q.size() < 8 || !is_hit(router_q[0])))
            wait_cnt++;
        else
            wait_cnt = 0;
        checks++;
        if (wait_cnt > 3) begin
            fails++;
            $display("FAIL pop_latency: got %0d idle cycles want <= 3", wait_cnt);
        end
        did_rst = 0;
        if (rst_on_pop && p_s) begin
            rst_n = 1'b0;
            did_rst = 1;
        end
        prev_pop = p_s;
        @(posedge clk);
        #1;
        if (did_rst) begin
            if (p_s) void'(router_q.pop_front());
            clear_model();
            rst_n = 1'b1;
        end else begin
            tcyc++;
            if (r_s && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
                void'(ts_q.pop_front());
            end
            if (p_s) begin
                void'(router_q.pop_front());
                if (is_hit(d_s)) begin
                    checks++;
                    if (fifo_q.size() >= 8) begin
                        fails++;
                        $display("FAIL pop_when_full: got pop of %h want no pop", d_s);
                    end else begin
                        fifo_q.push_back(d_s);
                        ts_q.push_back(cyc_s);
                        if (rx_m < 65535) rx_m++;
                    end
                end else if (mis_m < 65535) begin
                    mis_m++;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pop, rd_valid, full} !== 3'b000 || rx_cnt !== 16'd0 || mis_cnt !== 16'd0 ||
            rd_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: got pop=%b v=%b f=%b rx=%0d mis=%0d d=%h want all 0",
                     pop, rd_valid, full, rx_cnt, mis_cnt, rd_data);
        end
    endtask

    task automatic test_match();
        int p0;
        do_reset();
        p0 = pops;
        router_q.push_back(32'h0012_1234);
        step(0);
        checks++;
        if (pop_seen !== 1'b0) begin
            fails++;
            $display("FAIL match_pop_early: got %b want 0", pop_seen);
        end
        step(0);
        checks++;
        if (pop_seen !== 1'b1) begin
            fails++;
            $display("FAIL match_pop_latency: got %b want 1", pop_seen);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0012_1234 || rx_cnt !== 16'd1) begin
            fails++;
            $display("FAIL match_accept: got v=%b d=%h rx=%0d want 1 00121234 1",
                     rd_valid, rd_data, rx_cnt);
        end
        repeat (4) step(0);
        checks++;
        if (pops - p0 != 1) begin
            fails++;
            $display("FAIL match_single_pop: got %0d want 1", pops - p0);
        end
        repeat (2) step(1);
    endtask

    task automatic test_misroute();
        do_reset();
        router_q.push_back(mk_pkt(8'h30));
        repeat (5) step(0);
        checks++;
        if (rd_valid !== 1'b0 || mis_cnt !== 16'd1 || rx_cnt !== 16'd0) begin
            fails++;
            $display("FAIL misroute: got v=%b mis=%0d rx=%0d want 0 1 0", rd_valid, mis_cnt, rx_cnt);
        end
    endtask

    task automatic test_broadcast();
        do_reset();
        router_q.push_back(mk_pkt(8'hFF));
        repeat (5) step(0);
        checks++;
        if (rd_valid !== 1'b1 || rx_cnt !== 16'd1 || mis_cnt !== 16'd0) begin
            fails++;
            $display("FAIL broadcast: got v=%b rx=%0d mis=%0d want 1 1 0", rd_valid, rx_cnt, mis_cnt);
        end
        repeat (2) step(1);
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        for (int i = 0; i < 10; i++) router_q.push_back(mk_pkt((i % 3 == 0) ? 8'hFF : 8'h12));
        p0 = pops;
        repeat (40) step(0);
        checks++;
        if (pops - p0 != 8 || full !== 1'b1 || router_q.size() != 2) begin
            fails++;
            $display("FAIL backpressure: got pops=%0d full=%b left=%0d want 8 1 2",
                     pops - p0, full, router_q.size());
        end
        p0 = pops;
        step(1);
        repeat (3) step(0);
        checks++;
        if (pops - p0 != 1 || full !== 1'b1) begin
            fails++;
            $display("FAIL read_unblock: got pops=%0d full=%b want 1 1", pops - p0, full);
        end
    endtask

    task automatic test_full_mismatch();
        int unsigned m0;
        m0 = mis_m;
        router_q.push_front(mk_pkt(8'h55));
        repeat (6) step(0);
        checks++;
        if (mis_cnt !== 16'(m0 + 1) || full !== 1'b1 || router_q.size() != 1) begin
            fails++;
            $display("FAIL full_mismatch: got mis=%0d full=%b left=%0d want %0d 1 1",
                     mis_cnt, full, router_q.size(), m0 + 1);
        end
        repeat (24) step(1);
    endtask

    task automatic test_reset_in_pop();
        bit seen;
        do_reset();
        for (int i = 0; i < 3; i++) router_q.push_back(mk_pkt(8'h12));
        repeat (12) step(0);
        router_q.push_back(mk_pkt(8'h12));
        rst_on_pop = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0);
            seen = did_rst;
        end
        rst_on_pop = 0;
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_in_pop_reached: got no pop want pop within 10 cycles");
        end
        checks++;
        if ({pop, rd_valid, full} !== 3'b000 || rx_cnt !== 16'd0 || mis_cnt !== 16'd0 ||
            rd_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_in_pop: got pop=%b v=%b f=%b rx=%0d mis=%0d d=%h want all 0",
                     pop, rd_valid, full, rx_cnt, mis_cnt, rd_data);
        end
        router_q.push_back(mk_pkt(8'h12));
        step(0);
        step(0);
        checks++;
        if (pop_seen !== 1'b1) begin
            fails++;
            $display("FAIL reset_to_idle: got pop=%b want 1", pop_seen);
        end
        repeat (3) step(1);
    endtask

    task automatic test_random();
        logic [7:0] tgt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (router_q.size() < 3 && $urandom_range(2) == 0) begin
                case ($urandom_range(3))
                    0:       tgt = 8'h12;
                    1:       tgt = 8'hFF;
                    2:       tgt = 8'h12;
                    default: tgt = 8'($urandom);
                endcase
                router_q.push_back(mk_pkt(tgt));
            end
            step(($urandom_range(3) == 0) ? 1'b1 : 1'b0);
        end
        repeat (30) step(1);
    endtask

`ifdef TERM_RX_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        repeat (4) step(0);
        router_q.push_back(mk_pkt(8'h12));
        step(0);
        step(0);
        checks++;
        if (ts !== 32'd5) begin
            fails++;
            $display("FAIL timestamp: got %0d want 5", ts);
        end
        repeat (2) step(1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        pndng = 1'b0;
        rd_en = 1'b0;
        data  = 32'h0;
        rst_on_pop = 0;
        did_rst = 0;
        test_reset();
        test_match();
        test_misroute();
        test_broadcast();
        test_back_to_back();
        test_full_mismatch();
        test_reset_in_pop();
        test_random();
`ifdef TERM_RX_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
